pipe_shifter: RTL
=================

PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width; legal values are powers of two from 8 to 64.
REQ-002 SHALL have parameter PIPE, default 2, meaning the number of register stages; legal values are 1..log2(XLEN).
REQ-003 SHALL have parameter TAG_W, default 5, meaning the width of the sideband tag (e.g. rd index).
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1, request present.
REQ-007 SHALL have port in_ready, output, 1, request accepted this cycle when high together with in_valid.
REQ-008 SHALL have port in_a, input, XLEN, operand.
REQ-009 SHALL have port in_shamt, input, log2(XLEN), shift amount.
REQ-010 SHALL have port in_op, input, 3, operation: 000 SRL, 001 SLL, 010 SRA, 100 ROR, 101 ROL, others reserved.
REQ-011 SHALL have port in_tag, input, TAG_W, sideband tag returned unchanged with the result.
REQ-012 SHALL have port flush, input, 1, synchronous kill of all in-flight operations.
REQ-013 SHALL have port out_valid, output, 1, result present.
REQ-014 SHALL have port out_ready, input, 1, consumer takes the result when high together with out_valid.
REQ-015 SHALL have port out_result, output, XLEN, shifted value.
REQ-016 SHALL have port out_tag, output, TAG_W, tag of the result.

Function
REQ-017 SHALL compute SRL as a logical right shift (zero fill), SLL as a left shift (zero fill) and SRA as a right shift with sign fill from in_a[XLEN-1].
REQ-018 SHALL use every in_shamt bit; shamt 0 returns in_a unchanged for every op.
REQ-019 SHALL return in_a unchanged for reserved op codes (011, 110, 111).
REQ-020 SHALL implement a log2(XLEN)-level barrel shifter split across PIPE register stages, each stage carrying valid, partial result, remaining op/shamt and tag.
REQ-021 SHALL deliver out_valid exactly PIPE cycles after acceptance when out_ready is held high.
REQ-022 SHALL sustain a throughput of one accepted operation per cycle with no backpressure.
REQ-023 SHALL use elastic stage flow: a stage loads when it is empty or its contents advance in the same cycle; stages with a valid hole ahead close the gap (no bubble lock).
REQ-024 SHALL drive in_ready = (stage 0 empty OR stage 0 advancing) AND NOT flush, combinationally.
REQ-025 SHALL hold out_valid, out_result and out_tag stable while out_valid=1 and out_ready=0.
REQ-026 SHALL return results in acceptance order with no loss or duplication.
REQ-027 SHALL, on flush=1 at a clock edge, clear every stage valid bit; no request is accepted that cycle, and an output handshake completing in the same cycle is still counted as delivered.
REQ-028 SHALL drive out_result and out_tag to 0 whenever out_valid=0.

Reset
REQ-029 SHALL, while rst_n=0, immediately clear all stage valid bits, force out_valid=0 and out_result=0/out_tag=0, and keep in_ready=0.
REQ-030 SHALL discard in-flight operations when reset asserts mid-operation; none reappears after release.
REQ-031 SHALL drive in_ready=1 in the first cycle after rst_n deasserts.

Configuration
REQ-032 SHALL include the ROR/ROL datapath when macro PIPE_SHIFTER_ROTATE_EN is defined: ROR rotates right by shamt, ROL rotates left by shamt.
REQ-033 SHALL, when PIPE_SHIFTER_ROTATE_EN is undefined, omit the rotate logic and treat 100/101 as reserved (return in_a unchanged); all other behaviour is identical.

Verification (XLEN=32, PIPE=2, TAG_W=5)
REQ-034 SHALL cover: SRA in_a=0x80000000, shamt=4, tag=7 -> out_result=0xF8000000, out_tag=7, out_valid exactly 2 cycles after acceptance.
REQ-035 SHALL cover: SRL 0x80000000 shamt 31 -> 0x00000001, and SLL 0x00000001 shamt 31 -> 0x80000000, issued back to back -> two consecutive out_valid cycles in order.
REQ-036 SHALL cover: out_ready=0 while 3 ops are issued -> in_ready drops after 2 accepts, output is held stable, and all 3 results emerge in order once out_ready=1.
REQ-037 SHALL cover: 2 ops in flight, then flush=1 for one cycle with in_valid=1 -> in_ready=0 that cycle, and no out_valid follows.
REQ-038 SHALL cover: rst_n pulsed low with 2 ops in flight -> out_valid=0 immediately and stays 0, and in_ready=1 one cycle after release.
REQ-039 SHALL cover: ROR 0x00000001 shamt 1 -> 0x80000000 with PIPE_SHIFTER_ROTATE_EN defined, and 0x00000001 without it.

Source files
------------

// File: rtl/pipe_shifter.sv
// Purpose: pipelined barrel shifter (SRL/SLL/SRA, optional ROR/ROL) with a sideband tag.
// Latency: PIPE cycles from acceptance to out_valid when out_ready is held high.
// Backpressure: elastic valid/ready stages; a stalled output freezes only the stages behind it.
//
// Optional feature: define PIPE_SHIFTER_ROTATE_EN to build the ROR (100) / ROL (101)
// datapath. Without it those codes are reserved and return in_a unchanged.
//
// Ports:
//   clk, rst_n                 single rising-edge clock, async active-low reset
//   in_valid/in_ready          request handshake; in_ready is combinational
//   in_a, in_shamt, in_op      operand, shift amount (log2(XLEN) bits), operation code
//   in_tag                     sideband tag returned unchanged with the result
//   flush                      synchronous kill of every in-flight operation
//   out_valid/out_ready        result handshake
//   out_result, out_tag        result and its tag, both forced to 0 while out_valid=0
module pipe_shifter #(
    parameter int XLEN  = 32,
    parameter int PIPE  = 2,
    parameter int TAG_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_a,
    input  logic [$clog2(XLEN)-1:0] in_shamt,
    input  logic [2:0]              in_op,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_result,
    output logic [TAG_W-1:0]        out_tag
);
    localparam int SHW = $clog2(XLEN);

    // Stage registers
    logic [PIPE-1:0]  vld_q;
    logic [XLEN-1:0]  dat_q [PIPE];
    logic [2:0]       op_q  [PIPE];
    logic [SHW-1:0]   sh_q  [PIPE];
    logic [TAG_W-1:0] tag_q [PIPE];

    // Inputs presented to each stage and the value it will capture
    logic [PIPE-1:0]  src_vld;
    logic [XLEN-1:0]  src_dat [PIPE];
    logic [2:0]       src_op  [PIPE];
    logic [SHW-1:0]   src_sh  [PIPE];
    logic [TAG_W-1:0] src_tag [PIPE];
    logic [XLEN-1:0]  dat_nxt [PIPE];

    // ld: stage may capture this cycle; adv: stage contents move on this cycle
    logic [PIPE-1:0]  ld;
    logic [PIPE-1:0]  adv;
    logic             accept;

    // One barrel level: shift x by the constant distance k according to op.
    // Applying the levels one after another composes into the full shift because
    // every operation is additive in its distance (SRA keeps the msb at each level).
    function automatic logic [XLEN-1:0] shift_lvl(input logic [XLEN-1:0] x,
                                                  input logic [2:0]      op,
                                                  input int              k);
        logic [XLEN-1:0] r;
        r = x;
        case (op)
            3'b000:  r = x >> k;
            3'b001:  r = x << k;
            3'b010:  r = XLEN'($signed(x) >>> k);
`ifdef PIPE_SHIFTER_ROTATE_EN
            3'b100:  r = (x >> k) | (x << (XLEN - k));
            3'b101:  r = (x << k) | (x >> (XLEN - k));
`endif
            default: r = x;
        endcase
        return r;
    endfunction

    // Flow control, resolved from the output back towards the input so a hole
    // anywhere in the pipe is filled in the same cycle.
    always_comb begin
        ld  = '0;
        adv = '0;
        adv[PIPE-1] = vld_q[PIPE-1] && out_ready;
        ld[PIPE-1]  = !vld_q[PIPE-1] || adv[PIPE-1];
        for (int s = PIPE - 2; s >= 0; s--) begin
            adv[s] = vld_q[s] && ld[s+1];
            ld[s]  = !vld_q[s] || adv[s];
        end
    end

    // rst_n is in the ready term so nothing is offered as accepted while in reset.
    assign in_ready = rst_n && ld[0] && !flush;
    assign accept   = in_valid && in_ready;

    // Stage sources: stage 0 takes the request port, stage s takes stage s-1.
    always_comb begin
        src_vld[0] = accept;
        src_dat[0] = in_a;
        src_op[0]  = in_op;
        src_sh[0]  = in_shamt;
        src_tag[0] = in_tag;
        for (int s = 1; s < PIPE; s++) begin
            src_vld[s] = vld_q[s-1];
            src_dat[s] = dat_q[s-1];
            src_op[s]  = op_q[s-1];
            src_sh[s]  = sh_q[s-1];
            src_tag[s] = tag_q[s-1];
        end
    end

    // Barrel levels are spread evenly: level l (distance 2^l) lives in stage
    // floor(l*PIPE/SHW), which gives every stage at least one level.
    always_comb begin
        for (int s = 0; s < PIPE; s++) begin
            dat_nxt[s] = src_dat[s];
            for (int l = 0; l < SHW; l++) begin
                if ((((l * PIPE) / SHW) == s) && src_sh[s][l]) begin
                    dat_nxt[s] = shift_lvl(dat_nxt[s], src_op[s], 1 << l);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int s = 0; s < PIPE; s++) begin
                dat_q[s] <= '0;
                op_q[s]  <= '0;
                sh_q[s]  <= '0;
                tag_q[s] <= '0;
            end
        end else if (flush) begin
            vld_q <= '0;
        end else begin
            for (int s = 0; s < PIPE; s++) begin
                if (ld[s]) begin
                    vld_q[s] <= src_vld[s];
                    // Payload only moves with a valid op; bubbles leave it untouched.
                    if (src_vld[s]) begin
                        dat_q[s] <= dat_nxt[s];
                        op_q[s]  <= src_op[s];
                        sh_q[s]  <= src_sh[s];
                        tag_q[s] <= src_tag[s];
                    end
                end
            end
        end
    end

    assign out_valid  = vld_q[PIPE-1];
    assign out_result = out_valid ? dat_q[PIPE-1] : '0;
    assign out_tag    = out_valid ? tag_q[PIPE-1] : '0;

endmodule
